// File: rtl/decoder_scan_n.sv
// rtl/decoder_scan_n.sv - registered N-to-2**N one-hot decoder with a prescaled walking-one scan mode.
// Optional macro DECODER_TRISTATE_EN: y floats while the registered enable is low.
module decoder_scan_n #(
  parameter int N        = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e,
  input  logic              mode,
  input  logic [N-1:0]      i,
  input  logic              ld,
  output logic [2**N-1:0]   y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W  = 2**N;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [W-1:0]  y_q, y_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] k);
    onehot    = '0;
    onehot[k] = 1'b1;
  endfunction

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    y_d    = '0;
    wrap_d = 1'b0;
    if (e) begin
      // A load (direct mode or ld) wins over a terminal count: no step, no wrap.
      if (!mode || ld) begin
        idx_d = i;
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        idx_d  = idx_q + 1'b1;
        wrap_d = (idx_q == {N{1'b1}});
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      y_d = onehot(idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign idx  = idx_q;
  assign wrap = wrap_q;

`ifdef DECODER_TRISTATE_EN
  logic en_q, en_d;

  always_comb begin
    en_d = e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= en_d;
    end
  end

  assign y = en_q ? y_q : {W{1'bz}};
`else
  assign y = y_q;
`endif

endmodule

// File: tb/tb_decoder_scan_n.sv
// tb/tb_decoder_scan_n.sv - directed self-checking bench for decoder_scan_n (N=3/SCAN_DIV=2 and N=2/SCAN_DIV=1).
module tb_decoder_scan_n;

  logic       clk = 1'b0;
  logic       rst, e, mode, ld;
  logic [2:0] i;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;

  logic       rst2, e2, mode2, ld2;
  logic [1:0] i2;
  logic [3:0] y2;
  logic [1:0] idx2;
  logic       wrap2;

  logic [7:0] y_idle;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_scan_n #(.N(3), .SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .e(e), .mode(mode), .i(i), .ld(ld),
    .y(y), .idx(idx), .wrap(wrap)
  );

  decoder_scan_n #(.N(2), .SCAN_DIV(1)) dut2 (
    .clk(clk), .rst(rst2), .e(e2), .mode(mode2), .i(i2), .ld(ld2),
    .y(y2), .idx(idx2), .wrap(wrap2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; e = 1'b0; mode = 1'b0; ld = 1'b0; i = 3'd0;
    step(); step();
    total++; if (y !== y_idle) begin bad++; $display("FAIL reset_y got=%h want=%h", y, y_idle); end
    total++; if (idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", idx); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap); end
    rst = 1'b0;
    step();
    total++; if (y !== y_idle) begin bad++; $display("FAIL idle_y got=%h want=%h", y, y_idle); end
    total++; if (idx !== 3'd0) begin bad++; $display("FAIL idle_idx got=%0d want=0", idx); end
  endtask

  task automatic test_direct();
    mode = 1'b0; e = 1'b1; i = 3'd5;
    step();
    total++; if (y !== 8'b0010_0000) begin bad++; $display("FAIL direct5_y got=%h want=20", y); end
    total++; if (idx !== 3'd5) begin bad++; $display("FAIL direct5_idx got=%0d want=5", idx); end
    i = 3'd0; ld = 1'b1;
    step();
    total++; if (y !== 8'h01) begin bad++; $display("FAIL direct0_y got=%h want=01", y); end
    total++; if (idx !== 3'd0) begin bad++; $display("FAIL direct0_idx got=%0d want=0", idx); end
    ld = 1'b0; i = 3'd5;
    step();
    total++; if (y !== 8'h20) begin bad++; $display("FAIL direct5b_y got=%h want=20", y); end
  endtask

  task automatic test_enable();
    e = 1'b0; i = 3'd2;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (y !== y_idle) begin bad++; $display("FAIL dis_y[%0d] got=%h want=%h", k, y, y_idle); end
      total++; if (idx !== 3'd5) begin bad++; $display("FAIL dis_idx[%0d] got=%0d want=5", k, idx); end
    end
    e = 1'b1; i = 3'd5;
    step();
    total++; if (y !== 8'h20) begin bad++; $display("FAIL reen_y got=%h want=20", y); end
  endtask

  task automatic test_scan_wrap();
    logic [7:0] exp_y [5]  = '{8'h40, 8'h80, 8'h80, 8'h01, 8'h01};
    logic       exp_w [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mode = 1'b1; ld = 1'b1; i = 3'd6;
    step();
    total++; if (y !== 8'h40) begin bad++; $display("FAIL scan_load_y got=%h want=40", y); end
    ld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (y !== exp_y[k]) begin bad++; $display("FAIL scan_y[%0d] got=%h want=%h", k, y, exp_y[k]); end
      total++; if (wrap !== exp_w[k]) begin bad++; $display("FAIL scan_wrap[%0d] got=%b want=%b", k, wrap, exp_w[k]); end
    end
    total++; if (idx !== 3'd0) begin bad++; $display("FAIL scan_idx got=%0d want=0", idx); end
  endtask

  task automatic test_ld_priority();
    ld = 1'b1; i = 3'd3;
    step();
    ld = 1'b0;
    step();
    ld = 1'b1; i = 3'd2;
    step();
    total++; if (y !== 8'h04) begin bad++; $display("FAIL ldpri_y got=%h want=04", y); end
    total++; if (idx !== 3'd2) begin bad++; $display("FAIL ldpri_idx got=%0d want=2", idx); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL ldpri_wrap got=%b want=0", wrap); end
    i = 3'd7;
    step();
    ld = 1'b0;
    step();
    ld = 1'b1;
    step();
    total++; if (idx !== 3'd7) begin bad++; $display("FAIL ldpri7_idx got=%0d want=7", idx); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL ldpri7_wrap got=%b want=0", wrap); end
  endtask

  task automatic test_reset_mid_scan();
    logic [7:0] exp_y [4] = '{8'h01, 8'h02, 8'h02, 8'h04};
    ld = 1'b1; i = 3'd7;
    step();
    ld = 1'b0;
    step();
    rst = 1'b1;
    step();
    total++; if (y !== y_idle) begin bad++; $display("FAIL midrst_y got=%h want=%h", y, y_idle); end
    total++; if (idx !== 3'd0) begin bad++; $display("FAIL midrst_idx got=%0d want=0", idx); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL midrst_wrap got=%b want=0", wrap); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (y !== exp_y[k]) begin bad++; $display("FAIL postrst_y[%0d] got=%h want=%h", k, y, exp_y[k]); end
    end
  endtask

  task automatic test_resume_and_mode_switch();
    e = 1'b0;
    step(); step();
    total++; if (idx !== 3'd2) begin bad++; $display("FAIL hold_idx got=%0d want=2", idx); end
    e = 1'b1;
    step();
    total++; if (y !== 8'h04) begin bad++; $display("FAIL resume_y got=%h want=04", y); end
    step();
    total++; if (y !== 8'h08) begin bad++; $display("FAIL resume_step_y got=%h want=08", y); end
    mode = 1'b0; i = 3'd1;
    step();
    total++; if (y !== 8'h02) begin bad++; $display("FAIL m10_y got=%h want=02", y); end
    mode = 1'b1;
    step();
    total++; if (y !== 8'h02) begin bad++; $display("FAIL m01_hold_y got=%h want=02", y); end
    step();
    total++; if (y !== 8'h04) begin bad++; $display("FAIL m01_step_y got=%h want=04", y); end
  endtask

  task automatic test_scan_div1();
    logic [3:0] exp_y [4] = '{4'h2, 4'h4, 4'h8, 4'h1};
    logic       exp_w [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    rst2 = 1'b0; e2 = 1'b1; mode2 = 1'b1; ld2 = 1'b1; i2 = 2'd0;
    step();
    total++; if (y2 !== 4'h1) begin bad++; $display("FAIL div1_load_y got=%h want=1", y2); end
    ld2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (y2 !== exp_y[k]) begin bad++; $display("FAIL div1_y[%0d] got=%h want=%h", k, y2, exp_y[k]); end
      total++; if (wrap2 !== exp_w[k]) begin bad++; $display("FAIL div1_wrap[%0d] got=%b want=%b", k, wrap2, exp_w[k]); end
    end
  endtask

  initial begin
`ifdef DECODER_TRISTATE_EN
    y_idle = 8'hzz;
`else
    y_idle = 8'h00;
`endif
    rst2 = 1'b1; e2 = 1'b0; mode2 = 1'b0; ld2 = 1'b0; i2 = 2'd0;
    test_reset();
    test_direct();
    test_enable();
    test_scan_wrap();
    test_ld_priority();
    test_reset_mid_scan();
    test_resume_and_mode_switch();
    test_scan_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
